// File: rtl/centroid_pkg.sv
// centroid_pkg: shared types, widths and helpers for the centroid accumulator
package centroid_pkg;
  localparam int SUM_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, ISSUE_X, ISSUE_Y, WAIT} state_t;
  function automatic int wait_timeout(input int latency);
    return latency + 4;
  endfunction
  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a, input logic [SUM_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/centroid_accumulator_if.sv
// centroid_accumulator_if: request/result bus to the shared pipelined divider
interface centroid_accumulator_if;
  import centroid_pkg::*;
  logic [SUM_WIDTH-1:0] dividend;
  logic [SUM_WIDTH-1:0] divisor;
  logic valid;
  logic [SUM_WIDTH-1:0] quotient;
  logic result_valid;
  modport master(output dividend, divisor, valid, input quotient, result_valid);
  modport slave(input dividend, divisor, valid, output quotient, result_valid);
endinterface

// File: rtl/coord_accumulator.sv
// coord_accumulator: saturating per-frame coordinate sums and pixel count with snapshot-and-clear
module coord_accumulator
  import centroid_pkg::*;
#(
  parameter int HWIDTH = 11,
  parameter int VWIDTH = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic hit,
  input  logic clear,
  input  logic snap,
  input  logic [HWIDTH-1:0] hcount,
  input  logic [VWIDTH-1:0] vcount,
  output logic [SUM_WIDTH-1:0] snap_sum_x,
  output logic [SUM_WIDTH-1:0] snap_sum_y,
  output logic [SUM_WIDTH-1:0] snap_count,
  output logic [SUM_WIDTH-1:0] next_count
);
  logic [SUM_WIDTH-1:0] sum_x, sum_y, count, next_x, next_y;
  always_comb begin
    next_x = hit ? sat_add(sum_x, SUM_WIDTH'(hcount)) : sum_x;
    next_y = hit ? sat_add(sum_y, SUM_WIDTH'(vcount)) : sum_y;
    next_count = hit ? sat_add(count, SUM_WIDTH'(1)) : count;
  end
  // the snapshot takes the post-add values so a pixel coinciding with clear is kept
  always_ff @(posedge clk_in)
    if (rst_in) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
      snap_sum_x <= '0;
      snap_sum_y <= '0;
      snap_count <= '0;
    end else begin
      sum_x <= clear ? '0 : next_x;
      sum_y <= clear ? '0 : next_y;
      count <= clear ? '0 : next_count;
      if (snap) begin
        snap_sum_x <= next_x;
        snap_sum_y <= next_y;
        snap_count <= next_count;
      end
    end
endmodule

// File: rtl/centroid_accumulator.sv
// centroid_accumulator: per-frame mask centroid computed through the shared pipelined divider
module centroid_accumulator
  import centroid_pkg::*;
#(
  parameter int HWIDTH = 11,
  parameter int VWIDTH = 10,
  parameter int MIN_PIXELS = 16,
  parameter int DIV_LATENCY = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic [HWIDTH-1:0] hcount_in,
  input  logic [VWIDTH-1:0] vcount_in,
  input  logic pixel_valid_in,
  input  logic mask_in,
  input  logic frame_end_in,
  centroid_accumulator_if.master div,
  output logic [HWIDTH-1:0] x_out,
  output logic [VWIDTH-1:0] y_out,
  output logic centroid_valid_out,
  output logic no_detect_out,
  output logic frame_dropped_out,
  output logic busy_out
);
  localparam int TIMEOUT = wait_timeout(DIV_LATENCY);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [HWIDTH-1:0] x_hold;
  logic [SUM_WIDTH-1:0] snap_sum_x, snap_sum_y, snap_count, next_count;
  logic got_x, accept, low, done, expire;
  coord_accumulator #(.HWIDTH(HWIDTH), .VWIDTH(VWIDTH)) acc (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hit(pixel_valid_in && mask_in),
    .clear(frame_end_in),
    .snap(accept),
    .hcount(hcount_in),
    .vcount(vcount_in),
    .snap_sum_x(snap_sum_x),
    .snap_sum_y(snap_sum_y),
    .snap_count(snap_count),
    .next_count(next_count)
  );
  always_comb begin
    accept = frame_end_in && state == IDLE;
    low = next_count < SUM_WIDTH'(MIN_PIXELS);
    done = state == WAIT && div.result_valid && got_x;
    expire = state == WAIT && timer == TW'(TIMEOUT - 1) && !done;
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept && !low ? ISSUE_X : IDLE;
      ISSUE_X: state_nx = ISSUE_Y;
      ISSUE_Y: state_nx = WAIT;
      default: state_nx = done || expire ? IDLE : WAIT;
    endcase
    div.valid = state == ISSUE_X || state == ISSUE_Y;
    div.dividend = state == ISSUE_X ? snap_sum_x : snap_sum_y;
    div.divisor = snap_count;
    busy_out = state != IDLE;
  end
  // results come back in issue order: x first, then y
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state <= IDLE;
      timer <= '0;
      got_x <= 1'b0;
      x_hold <= '0;
      x_out <= '0;
      y_out <= '0;
      centroid_valid_out <= 1'b0;
      no_detect_out <= 1'b0;
      frame_dropped_out <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= state == WAIT ? timer + 1'b1 : '0;
      got_x <= state == WAIT && !done && !expire && (got_x || div.result_valid);
      if (state == WAIT && div.result_valid && !got_x) x_hold <= div.quotient[HWIDTH-1:0];
      if (done) begin
        x_out <= x_hold;
        y_out <= div.quotient[VWIDTH-1:0];
      end
      centroid_valid_out <= done;
      no_detect_out <= accept && low;
      frame_dropped_out <= (frame_end_in && state != IDLE) || expire;
    end
endmodule

// File: tb/tb_centroid_accumulator.sv
// tb_centroid_accumulator: randomized scoreboard bench with a pipelined divider model attached
module tb_centroid_accumulator;
  import centroid_pkg::*;
  localparam int HW = 11;
  localparam int VW = 10;
  localparam int MINP = 16;
  localparam int L = 16;
  typedef struct {longint a; longint b; longint c;} ev_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [HW-1:0] hcount_in = '0;
  logic [VW-1:0] vcount_in = '0;
  logic pixel_valid_in = 1'b0, mask_in = 1'b0, frame_end_in = 1'b0;
  logic [HW-1:0] x_out;
  logic [VW-1:0] y_out;
  logic centroid_valid_out, no_detect_out, frame_dropped_out, busy_out;
  centroid_accumulator_if div();
  centroid_accumulator #(.HWIDTH(HW), .VWIDTH(VW), .MIN_PIXELS(MINP), .DIV_LATENCY(L)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .pixel_valid_in(pixel_valid_in),
    .mask_in(mask_in),
    .frame_end_in(frame_end_in),
    .div(div.master),
    .x_out(x_out),
    .y_out(y_out),
    .centroid_valid_out(centroid_valid_out),
    .no_detect_out(no_detect_out),
    .frame_dropped_out(frame_dropped_out),
    .busy_out(busy_out)
  );
  int vectors = 0, fails = 0;
  longint cyc = 0, idle_at = 0, acc_x = 0, acc_y = 0, acc_n = 0, last_x = 0, last_y = 0;
  ev_t q[4][$];
  string names[4] = '{"div_req", "centroid", "no_detect", "frame_dropped"};
  bit stub = 1'b0, second = 1'b0;
  logic pv[L] = '{default: 1'b0};
  logic [31:0] pq[L] = '{default: 32'd0};

  initial forever #5 clk_in = ~clk_in;

  // divider model: quotient appears DIV_LATENCY cycles after the request; stub mode loses every y request
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (div.valid) second <= !second;
    pv[0] <= div.valid && !(stub && second);
    pq[0] <= div.divisor == 0 ? 32'd0 : div.dividend / div.divisor;
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pq[i] <= pq[i-1];
    end
  end
  assign div.result_valid = pv[L-1];
  assign div.quotient = pq[L-1];

  always @(negedge clk_in) begin
    logic seen[4];
    longint a[4], b[4];
    ev_t e;
    seen = '{div.valid, centroid_valid_out, no_detect_out, frame_dropped_out};
    a = '{longint'(div.dividend), longint'(x_out), 64'd0, 64'd0};
    b = '{longint'(div.divisor), longint'(y_out), 64'd0, 64'd0};
    for (int k = 0; k < 4; k++) begin
      while (q[k].size() != 0 && q[k][0].c < cyc) begin
        vectors++;
        fails++;
        $display("FAIL %s missing: required at cycle %0d, nothing observed by cycle %0d", names[k], q[k][0].c, cyc);
        void'(q[k].pop_front());
      end
      if (seen[k] === 1'b1) begin
        vectors++;
        if (q[k].size() == 0) begin
          fails++;
          $display("FAIL %s unexpected at cycle %0d a=%0d b=%0d, required none", names[k], cyc, a[k], b[k]);
        end else begin
          e = q[k].pop_front();
          if (e.c != cyc || a[k] != e.a || b[k] != e.b) begin
            fails++;
            $display("FAIL %s got cycle %0d a=%0d b=%0d, required cycle %0d a=%0d b=%0d", names[k], cyc, a[k], b[k], e.c, e.a, e.b);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step(input int h, input int v, input bit pv_i, input bit m, input bit fe, input bit r);
    bit hit;
    longint sx, sy, n;
    hcount_in = HW'(h);
    vcount_in = VW'(v);
    pixel_valid_in = pv_i;
    mask_in = m;
    frame_end_in = fe;
    rst_in = r;
    hit = pv_i && m;
    if (r) begin
      acc_x = 0;
      acc_y = 0;
      acc_n = 0;
      last_x = 0;
      last_y = 0;
      idle_at = cyc + 1;
      for (int k = 0; k < 4; k++) q[k].delete();
    end else if (fe) begin
      if (cyc >= idle_at) begin
        sx = acc_x + (hit ? h : 0);
        sy = acc_y + (hit ? v : 0);
        n = acc_n + (hit ? 1 : 0);
        if (n < MINP) q[2].push_back('{0, 0, cyc + 1});
        else begin
          q[0].push_back('{sx, n, cyc + 1});
          q[0].push_back('{sy, n, cyc + 2});
          if (stub) begin
            q[3].push_back('{0, 0, cyc + L + 7});
            idle_at = cyc + L + 7;
          end else begin
            last_x = sx / n;
            last_y = sy / n;
            q[1].push_back('{last_x, last_y, cyc + L + 3});
            idle_at = cyc + L + 3;
          end
        end
      end else q[3].push_back('{0, 0, cyc + 1});
      acc_x = 0;
      acc_y = 0;
      acc_n = 0;
    end else if (hit) begin
      acc_x += h;
      acc_y += v;
      acc_n++;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    while (cyc < idle_at) idle();
    idle();
    chk("busy_idle", busy_out, 0);
  endtask

  // fe_mode: 0 no frame end, 1 frame end on the last pixel, 2 frame end one step after it
  task automatic frame(input int x0, input int y0, input int w, input int h, input int pct, input int fe_mode);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) begin
        bit last, m;
        last = fe_mode == 1 && x == x0 + w - 1 && y == y0 + h - 1;
        m = $urandom_range(99) < pct;
        step(x, y, 1, m, last, 0);
        if (!last && $urandom_range(3) == 0) step($urandom_range(2047), $urandom_range(1023), 0, 1, 0, 0);
      end
    if (fe_mode == 2) step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int w, h;
    repeat (3) step(0, 0, 0, 0, 0, 1);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_centroid_valid", centroid_valid_out, 0);
    chk("rst_no_detect", no_detect_out, 0);
    chk("rst_frame_dropped", frame_dropped_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_div_valid", div.valid, 0);
    frame(100, 50, 4, 4, 100, 2);
    wait_idle();
    frame(200, 300, 5, 3, 100, 2);
    wait_idle();
    chk("nodetect_x_hold", x_out, last_x);
    chk("nodetect_y_hold", y_out, last_y);
    frame(400, 200, 6, 6, 90, 2);
    repeat (4) step($urandom_range(2047), $urandom_range(1023), 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    frame(900, 600, 5, 5, 100, 0);
    wait_idle();
    step(0, 0, 0, 0, 1, 0);
    wait_idle();
    frame(600, 700, 4, 4, 100, 1);
    for (int i = 0; i < 15; i++) step(10 + i, 20, 1, 1, 0, 0);
    wait_idle();
    step(0, 0, 0, 0, 1, 0);
    wait_idle();
    stub = 1'b1;
    frame(300, 400, 4, 5, 100, 2);
    repeat (4) idle();
    stub = 1'b0;
    wait_idle();
    frame(1500, 800, 5, 4, 100, 2);
    wait_idle();
    chk("after_timeout_x", x_out, last_x);
    frame(50, 60, 5, 4, 100, 2);
    repeat (8) idle();
    chk("busy_in_wait", busy_out, cyc < idle_at);
    step(0, 0, 0, 0, 0, 1);
    chk("midrst_x", x_out, 0);
    chk("midrst_y", y_out, 0);
    chk("midrst_centroid_valid", centroid_valid_out, 0);
    chk("midrst_no_detect", no_detect_out, 0);
    chk("midrst_frame_dropped", frame_dropped_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_div_valid", div.valid, 0);
    repeat (30) idle();
    for (int f = 0; f < 25; f++) begin
      w = $urandom_range(1, 7);
      h = $urandom_range(1, 7);
      frame($urandom_range(0, 2047 - w), $urandom_range(0, 1023 - h), w, h, $urandom_range(30, 100), $urandom_range(1, 2));
      repeat ($urandom_range(0, 20)) idle();
    end
    wait_idle();
    for (int i = 0; i < 60 && (q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0; i++) idle();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (q[k].size() != 0) begin
        fails++;
        $display("FAIL %s leftover got %0d pending events, required 0", names[k], q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
